// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key expansion block and its neighbours.
// Holds the round count, the key-expansion FSM state encoding, the initial
// round constant and the GF(2^8) doubling used to step rcon.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT     = 2'd1,
    GENERATE = 2'd2
  } kx_state_t;

  // Multiply by x in GF(2^8) with the AES polynomial (xtime).
  function automatic logic [7:0] gm2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expansion_block_if.sv
// Signal bundle between the key expansion block and the encipher stage.
//   key       : cipher key, w0 in [127:96]
//   init      : start expansion (only honoured while ready=1)
//   round     : round-key index to read
//   round_key : stored key for index round (0 for 11..15)
//   sboxw     : word sent to the shared S-box
//   new_sboxw : S-box result, combinational in the same cycle
//   ready     : idle with all stored keys valid
interface key_expansion_block_if;

  logic [127:0] key;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;

  modport slave (
    input  key, init, round, new_sboxw,
    output round_key, sboxw, ready
  );

  modport master (
    output key, init, round, new_sboxw,
    input  round_key, sboxw, ready
  );

endinterface

// File: rtl/round_key_mem.sv
// Round-key storage: DEPTH slots of DW bits, one synchronous write port and
// one combinational read port. Reads of addresses past the last slot return 0.
//   clk, reset : clock, synchronous active-high clear of every slot
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module round_key_mem #(
  parameter int DEPTH = 11,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: this array is cleared on reset, so it maps to flops, not a RAM
  // macro; that is acceptable at 11 entries and lets reset wipe stale keys.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr <= LAST_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST_ADDR) ? mem[raddr] : '0;

endmodule

// File: rtl/key_expansion_block.sv
// AES-128 key expansion. On init, the cipher key is stored as round key 0,
// then one round key is derived per cycle using the external S-box shared
// with the encipher stage, and stored in slots 1..NUM_ROUNDS.
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   bus       : key_expansion_block_if.slave (key, init, round, round_key,
//               sboxw, new_sboxw, ready)
// NUM_ROUNDS must stay at 10; only AES-128 is supported.
module key_expansion_block
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic                  clk,
  input  logic                  reset,
  key_expansion_block_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  kx_state_t    state_q, state_d;
  logic [3:0]   round_ctr;
  logic [7:0]   rcon;
  logic [127:0] work_key;

  logic [31:0]  t, nw0, nw1, nw2, nw3;
  logic [127:0] next_key;

  logic         mem_we;
  logic [3:0]   mem_waddr;
  logic [127:0] mem_wdata;

  // State register.
  // NOTE: sequential state always uses non-blocking assignment so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. init is only looked at in IDLE, so it is ignored for
  // the whole expansion, including the edge on which ready rises.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.init) state_d = INIT;
      INIT:     state_d = GENERATE;
      GENERATE: if (round_ctr == LAST_ROUND) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // One key-schedule step: RotWord(SubWord(w3)) ^ rcon, then the xor chain.
  always_comb begin
    t        = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon, 24'h0};
    nw0      = work_key[127:96] ^ t;
    nw1      = work_key[95:64]  ^ nw0;
    nw2      = work_key[63:32]  ^ nw1;
    nw3      = work_key[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  // Outputs decoded from state.
  always_comb begin
    bus.ready = 1'b0;
    bus.sboxw = 32'h0;
    mem_we    = 1'b0;
    mem_waddr = 4'd0;
    mem_wdata = '0;
    case (state_q)
      IDLE: bus.ready = 1'b1;
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = 4'd0;
        mem_wdata = bus.key;
      end
      GENERATE: begin
        bus.sboxw = work_key[31:0];
        mem_we    = 1'b1;
        mem_waddr = round_ctr;
        mem_wdata = next_key;
      end
      default: ;
    endcase
  end

  // Working key, round counter and rcon.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_key  <= '0;
      round_ctr <= 4'd0;
      rcon      <= RCON_INIT;
    end else begin
      case (state_q)
        INIT: begin
          work_key  <= bus.key;
          round_ctr <= 4'd1;
          rcon      <= RCON_INIT;
        end
        GENERATE: begin
          work_key <= next_key;
          rcon     <= gm2(rcon);
          // Saturate so the counter never points past the last slot.
          if (round_ctr != LAST_ROUND) round_ctr <= round_ctr + 4'd1;
        end
        default: ;
      endcase
    end
  end

  round_key_mem #(
    .DEPTH (NUM_ROUNDS + 1),
    .AW    (4),
    .DW    (128)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.round),
    .rdata (bus.round_key)
  );

endmodule

// File: tb/tb_key_expansion_block.sv
// Bench for key_expansion_block: supplies the AES S-box, drives directed
// key-expansion scenarios and checks round keys, ready latency and sboxw
// through a scoreboard consumed by a negedge monitor.
module tb_key_expansion_block;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K_OTHER = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    string        name;
    logic [127:0] exp_key;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  key_expansion_block_if kif();

  key_expansion_block #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  // AES S-box model feeding new_sboxw combinationally.
  logic [7:0]   sbox_tab [256];
  logic [127:0] sbox_rows [16];

  initial begin
    sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sbox_tab[r*16 + c] = sbox_rows[r][127 - 8*c -: 8];
  end

  assign kif.new_sboxw = {sbox_tab[kif.sboxw[31:24]], sbox_tab[kif.sboxw[23:16]],
                          sbox_tab[kif.sboxw[15:8]],  sbox_tab[kif.sboxw[7:0]]};

  // Scoreboard queues, filled by stimulus and drained by the monitor.
  rd_exp_t      rd_q [$];
  int           lat_q [$];
  logic [31:0]  w3_q [$];
  logic         rd_req = 1'b0;
  logic         done   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int low_cnt  = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      low_cnt = 0;
      lat_q.delete();
      w3_q.delete();
    end else begin
      if (!kif.ready) begin
        low_cnt++;
        if (low_cnt == 1) begin
          check("sboxw_in_init", {96'h0, kif.sboxw}, 128'h0);
        end else if (low_cnt == 2 && w3_q.size() > 0) begin
          logic [31:0] w3;
          w3 = w3_q.pop_front();
          check("sboxw_first_generate", {96'h0, kif.sboxw}, {96'h0, w3});
        end
      end else begin
        check("sboxw_idle", {96'h0, kif.sboxw}, 128'h0);
        if (low_cnt != 0) begin
          if (lat_q.size() > 0) begin
            int exp_lat;
            exp_lat = lat_q.pop_front();
            check("ready_low_cycles", 128'(low_cnt), 128'(exp_lat));
          end else begin
            check("ready_low_unexpected", 128'(low_cnt), 128'h0);
          end
          low_cnt = 0;
        end
      end
      if (rd_req) begin
        if (rd_q.size() > 0) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check(e.name, kif.round_key, e.exp_key);
          check({e.name, "_ready"}, {127'h0, kif.ready}, 128'h1);
        end else begin
          check("read_without_expectation", 128'h1, 128'h0);
        end
      end
    end
    if (done) begin
      check("reads_drained",   128'(rd_q.size()),  128'h0);
      check("latency_drained", 128'(lat_q.size()), 128'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] r, input logic [127:0] exp,
                         input string name);
    rd_exp_t e;
    e.name    = name;
    e.exp_key = exp;
    rd_q.push_back(e);
    kif.round = r;
    rd_req    = 1'b1;
    tick();
    rd_req    = 1'b0;
  endtask

  // Issue an init that will be accepted on the next edge.
  task automatic start_expansion(input logic [127:0] k);
    kif.key  = k;
    kif.init = 1'b1;
    lat_q.push_back(11);
    w3_q.push_back(k[31:0]);
    tick();
    kif.init = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!kif.ready) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL wait_ready: ready still %b after %0d cycles, required 1", kif.ready, n);
        $fatal(1, "ready timeout");
      end
    end
  endtask

  initial begin
    kif.key   = '0;
    kif.init  = 1'b0;
    kif.round = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    do_read(4'd0,  128'h0, "reset_slot0");
    do_read(4'd10, 128'h0, "reset_slot10");

    // FIPS-197 key.
    start_expansion(K1);
    wait_ready();
    do_read(4'd0,  K1,     "k1_round0");
    do_read(4'd1,  K1_R1,  "k1_round1");
    do_read(4'd10, K1_R10, "k1_round10");

    // Out-of-range indices.
    do_read(4'd11, 128'h0, "round11_zero");
    do_read(4'd15, 128'h0, "round15_zero");

    // All-zero key with init held high: ignored during expansion and on the
    // edge ready rises, then accepted on the following idle edge.
    kif.key  = '0;
    kif.init = 1'b1;
    lat_q.push_back(11);
    w3_q.push_back(32'h0);
    tick();
    wait_ready();
    lat_q.push_back(11);
    w3_q.push_back(32'h0);
    tick();
    kif.init = 1'b0;
    wait_ready();
    do_read(4'd0,  128'h0, "k0_round0");
    do_read(4'd1,  K0_R1,  "k0_round1");
    do_read(4'd10, K0_R10, "k0_round10");

    // Init with a different key mid-expansion is ignored.
    start_expansion(K1);
    repeat (4) tick();
    kif.key  = K_OTHER;
    kif.init = 1'b1;
    tick();
    kif.init = 1'b0;
    wait_ready();
    do_read(4'd1,  K1_R1,  "midinit_round1");
    do_read(4'd10, K1_R10, "midinit_round10");

    // Reset during generation aborts and clears every slot.
    start_expansion(K1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      do_read(4'(i), 128'h0, $sformatf("abort_slot%0d", i));
    end

    // Fresh expansion after the abort.
    start_expansion(K1);
    wait_ready();
    do_read(4'd0,  K1,     "restart_round0");
    do_read(4'd1,  K1_R1,  "restart_round1");
    do_read(4'd10, K1_R10, "restart_round10");

    tick();
    tick();
    done = 1'b1;
    repeat (5) tick();
    $display("FAIL end_of_test: monitor did not close the run, required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
